// File: rtl/shift_register_univ.sv
// Universal WIDTH-bit register: hold, load, logical shift, rotate, clear, plus a saturating shift counter.
// Latency: one clock; the result of the operation sampled at an edge is on q right after that edge.
// Backpressure: none; en=0 freezes all state regardless of mode.
module shift_register_univ #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  localparam int              CW          = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_l,
  input  logic             sin_r,
  output logic [WIDTH-1:0] q,
  output logic             sout_msb,
  output logic             sout_lsb,
  output logic [CW-1:0]    shift_cnt,
  output logic             drained
);

  typedef enum logic [2:0] {
    MODE_HOLD = 3'b000,
    MODE_LOAD = 3'b001,
    MODE_SHL  = 3'b010,
    MODE_SHR  = 3'b011,
    MODE_ROL  = 3'b100,
    MODE_ROR  = 3'b101,
    MODE_CLR  = 3'b110,
    MODE_RSVD = 3'b111
  } mode_e;

  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

  logic [WIDTH-1:0] q_next;
  logic [CW-1:0]    cnt_next;
  logic             is_shift;

  // Next-state select: each mode only looks at the inputs it actually uses,
  // so an undriven sin_l/sin_r/d cannot leak into q under other modes.
  always_comb begin
    q_next   = q;
    cnt_next = shift_cnt;
    is_shift = 1'b0;
    if (en) begin
      case (mode_e'(mode))
        MODE_LOAD: begin
          q_next   = d;
          cnt_next = '0;
        end
        MODE_SHL: begin
          q_next   = {q[WIDTH-2:0], sin_l};
          is_shift = 1'b1;
        end
        MODE_SHR: begin
          q_next   = {sin_r, q[WIDTH-1:1]};
          is_shift = 1'b1;
        end
        MODE_ROL: begin
          q_next   = {q[WIDTH-2:0], q[WIDTH-1]};
          is_shift = 1'b1;
        end
        MODE_ROR: begin
          q_next   = {q[0], q[WIDTH-1:1]};
          is_shift = 1'b1;
        end
        MODE_CLR: begin
          // Clear goes to all-zeros, deliberately distinct from RESET_VALUE.
          q_next   = '0;
          cnt_next = '0;
        end
        default: begin
          // HOLD and the reserved encoding keep the current state.
          q_next   = q;
          cnt_next = shift_cnt;
        end
      endcase
      // Counter saturates at WIDTH so drained stays up until a load/clear/reset.
      if (is_shift && (shift_cnt != CNT_MAX)) begin
        cnt_next = shift_cnt + CW'(1);
      end
    end
  end

  // State register; synchronous reset overrides any pending operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      q         <= RESET_VALUE;
      shift_cnt <= '0;
    end else begin
      q         <= q_next;
      shift_cnt <= cnt_next;
    end
  end

  assign sout_msb = q[WIDTH-1];
  assign sout_lsb = q[0];
  assign drained  = (shift_cnt == CNT_MAX);

endmodule

// File: tb/tb_shift_register_univ.sv
// Directed bench for shift_register_univ (WIDTH=8, RESET_VALUE=8'h3C).
// Inputs change just after a rising edge; outputs are checked 1 ns after the edge.
module tb_shift_register_univ;

  localparam int WIDTH = 8;
  localparam int CW    = $clog2(WIDTH + 1);

  localparam logic [2:0] M_HOLD = 3'b000;
  localparam logic [2:0] M_LOAD = 3'b001;
  localparam logic [2:0] M_SHL  = 3'b010;
  localparam logic [2:0] M_SHR  = 3'b011;
  localparam logic [2:0] M_ROL  = 3'b100;
  localparam logic [2:0] M_ROR  = 3'b101;
  localparam logic [2:0] M_CLR  = 3'b110;
  localparam logic [2:0] M_RSVD = 3'b111;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic [2:0]       mode;
  logic [WIDTH-1:0] d;
  logic             sin_l;
  logic             sin_r;
  logic [WIDTH-1:0] q;
  logic             sout_msb;
  logic             sout_lsb;
  logic [CW-1:0]    shift_cnt;
  logic             drained;

  int checks = 0;
  int errors = 0;

  shift_register_univ #(
    .WIDTH      (WIDTH),
    .RESET_VALUE(8'h3C)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .mode     (mode),
    .d        (d),
    .sin_l    (sin_l),
    .sin_r    (sin_r),
    .q        (q),
    .sout_msb (sout_msb),
    .sout_lsb (sout_lsb),
    .shift_cnt(shift_cnt),
    .drained  (drained)
  );

  always #5 clk = ~clk;

  // Apply one operation for one edge, then settle past the edge.
  task automatic op(input logic e, input logic [2:0] m, input logic [7:0] dv,
                    input logic sl, input logic sr);
    en = e; mode = m; d = dv; sin_l = sl; sin_r = sr;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    en = 1'b1; mode = M_LOAD; d = 8'hFF; sin_l = 1'b1; sin_r = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++; if (q !== 8'h3C) begin errors++; $display("FAIL reset_q got %h exp %h", q, 8'h3C); end
    checks++; if (shift_cnt !== 4'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", shift_cnt); end
    checks++; if (drained !== 1'b0) begin errors++; $display("FAIL reset_drained got %b exp 0", drained); end
  endtask

  task automatic test_shl;
    logic [7:0] exp_q [3];
    exp_q[0] = 8'h4B; exp_q[1] = 8'h97; exp_q[2] = 8'h2F;
    op(1'b1, M_LOAD, 8'hA5, 1'b0, 1'b0);
    checks++; if (q !== 8'hA5) begin errors++; $display("FAIL load_q got %h exp a5", q); end
    checks++; if (shift_cnt !== 4'd0) begin errors++; $display("FAIL load_cnt got %0d exp 0", shift_cnt); end
    for (int i = 0; i < 3; i++) begin
      // sin_r toggled to show it is ignored under SHL
      op(1'b1, M_SHL, 8'h00, 1'b1, i[0]);
      checks++; if (q !== exp_q[i]) begin errors++; $display("FAIL shl_q[%0d] got %h exp %h", i, q, exp_q[i]); end
    end
    checks++; if (shift_cnt !== 4'd3) begin errors++; $display("FAIL shl_cnt got %0d exp 3", shift_cnt); end
  endtask

  task automatic test_rotate;
    op(1'b1, M_LOAD, 8'h81, 1'b0, 1'b0);
    checks++; if ({sout_msb, sout_lsb} !== 2'b11) begin errors++; $display("FAIL sout_81 got %b exp 11", {sout_msb, sout_lsb}); end
    op(1'b1, M_ROR, 8'h00, 1'b0, 1'b0);
    checks++; if (q !== 8'hC0) begin errors++; $display("FAIL ror_q got %h exp c0", q); end
    checks++; if ({sout_msb, sout_lsb} !== 2'b10) begin errors++; $display("FAIL sout_c0 got %b exp 10", {sout_msb, sout_lsb}); end
    op(1'b1, M_ROL, 8'h00, 1'b0, 1'b0);
    checks++; if (q !== 8'h81) begin errors++; $display("FAIL rol_q got %h exp 81", q); end
    checks++; if (shift_cnt !== 4'd2) begin errors++; $display("FAIL rot_cnt got %0d exp 2", shift_cnt); end
  endtask

  task automatic test_shr_drain;
    logic [7:0] exp_q [8];
    exp_q[0] = 8'h52; exp_q[1] = 8'h29; exp_q[2] = 8'h14; exp_q[3] = 8'h0A;
    exp_q[4] = 8'h05; exp_q[5] = 8'h02; exp_q[6] = 8'h01; exp_q[7] = 8'h00;
    op(1'b1, M_LOAD, 8'hA5, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      op(1'b1, M_SHR, 8'h00, 1'b1, 1'b0);
      checks++; if (q !== exp_q[i]) begin errors++; $display("FAIL shr_q[%0d] got %h exp %h", i, q, exp_q[i]); end
      if (i == 6) begin
        checks++; if ({shift_cnt, drained} !== {4'd7, 1'b0}) begin errors++; $display("FAIL shr7 cnt/drained got %0d/%b exp 7/0", shift_cnt, drained); end
      end
    end
    checks++; if (shift_cnt !== 4'd8) begin errors++; $display("FAIL shr8_cnt got %0d exp 8", shift_cnt); end
    checks++; if (drained !== 1'b1) begin errors++; $display("FAIL shr8_drained got %b exp 1", drained); end
    op(1'b1, M_SHR, 8'h00, 1'b0, 1'b0);
    checks++; if ({shift_cnt, drained} !== {4'd8, 1'b1}) begin errors++; $display("FAIL shr9 cnt/drained got %0d/%b exp 8/1", shift_cnt, drained); end
    op(1'b1, M_ROL, 8'h00, 1'b0, 1'b0);
    checks++; if (shift_cnt !== 4'd8) begin errors++; $display("FAIL sat_rol_cnt got %0d exp 8", shift_cnt); end
  endtask

  task automatic test_hold;
    // Continues from drained state q=00, cnt=8.
    op(1'b0, M_LOAD, 8'hFF, 1'b1, 1'b1);
    checks++; if ({q, shift_cnt} !== {8'h00, 4'd8}) begin errors++; $display("FAIL en0_hold got %h/%0d exp 00/8", q, shift_cnt); end
    op(1'b0, M_SHL, 8'hFF, 1'b1, 1'b1);
    checks++; if ({q, shift_cnt} !== {8'h00, 4'd8}) begin errors++; $display("FAIL en0_shl got %h/%0d exp 00/8", q, shift_cnt); end
    op(1'b1, M_RSVD, 8'hFF, 1'b1, 1'b1);
    checks++; if ({q, shift_cnt, drained} !== {8'h00, 4'd8, 1'b1}) begin errors++; $display("FAIL rsvd_hold got %h/%0d/%b exp 00/8/1", q, shift_cnt, drained); end
    op(1'b1, M_LOAD, 8'h6D, 1'b0, 1'b0);
    op(1'b1, M_HOLD, 8'hFF, 1'b1, 1'b1);
    checks++; if ({q, shift_cnt} !== {8'h6D, 4'd0}) begin errors++; $display("FAIL mode_hold got %h/%0d exp 6d/0", q, shift_cnt); end
  endtask

  task automatic test_clear;
    op(1'b1, M_LOAD, 8'h5A, 1'b0, 1'b0);
    op(1'b1, M_SHL, 8'h00, 1'b0, 1'b1);
    checks++; if ({q, shift_cnt} !== {8'hB4, 4'd1}) begin errors++; $display("FAIL pre_clr got %h/%0d exp b4/1", q, shift_cnt); end
    op(1'b1, M_CLR, 8'hFF, 1'b1, 1'b1);
    checks++; if ({q, shift_cnt, drained} !== {8'h00, 4'd0, 1'b0}) begin errors++; $display("FAIL clr got %h/%0d/%b exp 00/0/0", q, shift_cnt, drained); end
  endtask

  task automatic test_reset_mid;
    op(1'b1, M_LOAD, 8'h0F, 1'b0, 1'b0);
    op(1'b1, M_SHL, 8'h00, 1'b1, 1'b0);
    op(1'b1, M_SHL, 8'h00, 1'b1, 1'b0);
    checks++; if ({q, shift_cnt} !== {8'h3F, 4'd2}) begin errors++; $display("FAIL pre_rst got %h/%0d exp 3f/2", q, shift_cnt); end
    rst = 1'b1;
    op(1'b1, M_SHL, 8'h00, 1'b1, 1'b0);
    rst = 1'b0;
    checks++; if ({q, shift_cnt} !== {8'h3C, 4'd0}) begin errors++; $display("FAIL mid_rst got %h/%0d exp 3c/0", q, shift_cnt); end
    op(1'b1, M_SHL, 8'h00, 1'b0, 1'b0);
    checks++; if ({q, shift_cnt} !== {8'h78, 4'd1}) begin errors++; $display("FAIL post_rst got %h/%0d exp 78/1", q, shift_cnt); end
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; mode = M_HOLD; d = '0; sin_l = 1'b0; sin_r = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_shl();
    test_rotate();
    test_shr_drain();
    test_hold();
    test_clear();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
